layer_sequencer: RTL and testbench

Drives one `neuron` instance through a full fully-connected layer. For each of `N_NEURONS` neurons it:
- clears the neuron;
- streams `N_INPUTS` pixel/weight pairs from synchronous memories, with that neuron's bias;
- waits for the neuron's result and publishes it on a result port.

It sits between the pixel/weight/bias memories and the neuron datapath, on the initiator side of the neuron's `inp_ready`/`out_ready` protocol.

---
 rtl/layer_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_layer_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : layer_sequencer                                              |
// | Description : Runs one neuron datapath through a fully-connected layer.    |
// |               For each neuron: clear it, stream N_INPUTS pixel/weight      |
// |               pairs from 1-cycle-latency memories along with the neuron's  |
// |               bias, then wait for the neuron result and publish it.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk, reset          : rising-edge clock, async active-high reset         |
// |   start               : run request, honoured only when idle               |
// |   busy, done          : not-idle flag, one-cycle end-of-layer pulse        |
// |   pix_addr / pix_data : pixel memory (data 1 cycle after address)          |
// |   w_addr / w_data     : weight memory, address = neuron*N_INPUTS + i       |
// |   b_addr / b_data     : bias memory                                        |
// |   nrn_clr             : synchronous clear to the neuron                    |
// |   inp_ready, inp_data,: neuron input strobe and operands                   |
// |   weight, bias        :                                                    |
// |   nrn_out(_ready)     : neuron result and its strobe                       |
// |   res_valid/idx/data  : published result (one-cycle pulse)                 |
// +----------------------------------------------------------------------------+
// | Build option: define LAYER_SEQ_RELU_EN to clamp negative results to 0.    |
// +----------------------------------------------------------------------------+
module layer_sequencer #(
  parameter int N_INPUTS  = 784,
  parameter int N_NEURONS = 10,
  parameter int DATA_W    = 16,
  parameter int WA_W      = $clog2(N_INPUTS * N_NEURONS),
  localparam int PA_W     = (N_INPUTS  > 1) ? $clog2(N_INPUTS)  : 1,
  localparam int NI_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [PA_W-1:0]   pix_addr,
  input  logic [DATA_W-1:0] pix_data,
  output logic [WA_W-1:0]   w_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic [NI_W-1:0]   b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              nrn_clr,
  output logic              inp_ready,
  output logic [DATA_W-1:0] inp_data,
  output logic [DATA_W-1:0] weight,
  output logic [DATA_W-1:0] bias,
  input  logic [DATA_W-1:0] nrn_out,
  input  logic              nrn_out_ready,
  output logic              res_valid,
  output logic [NI_W-1:0]   res_idx,
  output logic [DATA_W-1:0] res_data
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_WAIT   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [PA_W-1:0] c_last_input  = PA_W'(N_INPUTS - 1);
  localparam logic [NI_W-1:0] c_last_neuron = NI_W'(N_NEURONS - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [PA_W-1:0]   r_pix_addr;
  logic [WA_W-1:0]   r_w_addr;
  logic [NI_W-1:0]   r_b_addr;
  logic [NI_W-1:0]   r_neuron_idx;
  logic              r_inp_ready;
  logic              r_res_valid;
  logic [NI_W-1:0]   r_res_idx;
  logic [DATA_W-1:0] r_res_data;

  logic              w_last_input;
  logic              w_last_neuron;
  logic              w_capture;
  logic              w_bias_en;
  logic [DATA_W-1:0] w_result;

  // The pixel address doubles as the input counter i.
  assign w_last_input  = (r_pix_addr == c_last_input);
  assign w_last_neuron = (r_neuron_idx == c_last_neuron);
  assign w_capture     = (r_state == S_WAIT) && nrn_out_ready;

`ifdef LAYER_SEQ_RELU_EN
  assign w_result = nrn_out[DATA_W-1] ? '0 : nrn_out;
`else
  assign w_result = nrn_out;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and state-decoded outputs
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b1;
    done         = 1'b0;
    nrn_clr      = 1'b0;
    w_bias_en    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_state_next = S_CLR;
      end
      S_CLR: begin
        nrn_clr      = 1'b1;
        w_state_next = S_STREAM;
      end
      S_STREAM: begin
        w_bias_en = 1'b1;
        if (w_last_input) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        w_bias_en    = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        w_bias_en = 1'b1;
        if (nrn_out_ready) w_state_next = w_last_neuron ? S_DONE : S_CLR;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Addresses, counters, strobe and result capture.
  // Addresses are registered and only move while streaming, so the memories
  // see a stable address (and the bias word stays put) outside STREAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pix_addr   <= '0;
      r_w_addr     <= '0;
      r_b_addr     <= '0;
      r_neuron_idx <= '0;
      r_inp_ready  <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_idx    <= '0;
      r_res_data   <= '0;
    end else begin
      r_res_valid <= 1'b0;
      // Data for the address issued this cycle arrives next cycle.
      r_inp_ready <= (r_state == S_STREAM);
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_neuron_idx <= '0;
            r_b_addr     <= '0;
          end
        end
        S_CLR: begin
          r_pix_addr <= '0;
          // Weight rows are contiguous: neuron n starts right after the
          // last word of neuron n-1, so no multiplier is needed.
          r_w_addr   <= (r_neuron_idx == '0) ? '0 : r_w_addr + WA_W'(1);
        end
        S_STREAM: begin
          if (!w_last_input) begin
            r_pix_addr <= r_pix_addr + PA_W'(1);
            r_w_addr   <= r_w_addr + WA_W'(1);
          end
        end
        S_WAIT: begin
          if (w_capture) begin
            r_res_valid <= 1'b1;
            r_res_idx   <= r_neuron_idx;
            r_res_data  <= w_result;
            if (!w_last_neuron) begin
              r_neuron_idx <= r_neuron_idx + NI_W'(1);
              r_b_addr     <= r_neuron_idx + NI_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign pix_addr  = r_pix_addr;
  assign w_addr    = r_w_addr;
  assign b_addr    = r_b_addr;
  assign inp_ready = r_inp_ready;
  assign res_valid = r_res_valid;
  assign res_idx   = r_res_idx;
  assign res_data  = r_res_data;

  // Operands are passed straight through from the memories but forced to
  // zero when not meaningful, so every output reads 0 while idle/reset.
  assign inp_data = r_inp_ready ? pix_data : '0;
  assign weight   = r_inp_ready ? w_data   : '0;
  assign bias     = w_bias_en   ? b_data   : '0;

endmodule
`default_nettype wire

// File: tb/tb_layer_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_layer_sequencer                                           |
// | Description : Self-checking bench for layer_sequencer. A small 4x2        |
// |               instance runs a table of vectors plus corner sequences; a   |
// |               default 784x10 instance runs one full layer. Each instance  |
// |               has 1-cycle memories and a behavioural Q8.8 neuron.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_layer_sequencer;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] post(input logic [15:0] v);
`ifdef LAYER_SEQ_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  typedef struct {
    int          idx;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  // ---------------- small instance: 4 inputs x 2 neurons ----------------
  logic        start0 = 1'b0;
  logic        busy0, done0, nrn_clr0, inp_ready0, res_valid0;
  logic [1:0]  pix_addr0;
  logic [2:0]  w_addr0;
  logic [0:0]  b_addr0, res_idx0;
  logic [15:0] pix_data0, w_data0, b_data0, inp_data0, weight0, bias0, res_data0;
  logic        nrdy0 = 1'b0;
  logic        spur0 = 1'b0;
  logic [15:0] nout0 = 16'h0;

  layer_sequencer #(.N_INPUTS(4), .N_NEURONS(2), .DATA_W(16)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .busy(busy0), .done(done0),
    .pix_addr(pix_addr0), .pix_data(pix_data0), .w_addr(w_addr0), .w_data(w_data0),
    .b_addr(b_addr0), .b_data(b_data0), .nrn_clr(nrn_clr0), .inp_ready(inp_ready0),
    .inp_data(inp_data0), .weight(weight0), .bias(bias0), .nrn_out(nout0),
    .nrn_out_ready(nrdy0 | spur0), .res_valid(res_valid0), .res_idx(res_idx0),
    .res_data(res_data0)
  );

  logic [15:0] pix_mem0 [4];
  logic [15:0] w_mem0   [8];
  logic [15:0] b_mem0   [2];
  always @(posedge clk) begin
    pix_data0 <= pix_mem0[pix_addr0];
    w_data0   <= w_mem0[w_addr0];
    b_data0   <= b_mem0[b_addr0];
  end

  // Behavioural neuron: accumulate (pix*w)>>>8, result = acc + bias,
  // ready the cycle after the 4th input.
  logic signed [31:0] acc0 = '0;
  int                 ncnt0 = 0;
  wire signed [31:0]  prod0 = ($signed(inp_data0) * $signed(weight0)) >>> 8;
  always @(posedge clk) begin
    nrdy0 <= 1'b0;
    if (reset || nrn_clr0) begin
      acc0  <= '0;
      ncnt0 <= 0;
    end else if (inp_ready0) begin
      acc0  <= acc0 + prod0;
      ncnt0 <= ncnt0 + 1;
      if (ncnt0 == 3) begin
        nrdy0 <= 1'b1;
        nout0 <= 16'(acc0 + prod0 + 32'($signed(bias0)));
      end
    end
  end

  exp_t q0[$];
  exp_t e0;
  bit   done_pend0 = 1'b0;
  int   done_exp0  = 0;
  int   inp_cnt0   = 0;
  bit   overlap0   = 1'b0;

  always @(negedge clk) begin
    if (inp_ready0) inp_cnt0++;
    if (inp_ready0 && nrn_clr0) overlap0 = 1'b1;
    if (res_valid0) begin
      if (q0.size() == 0) begin
        check("res_unexpected", 64'(res_valid0), 64'd0);
      end else begin
        e0 = q0.pop_front();
        check("res_data", 64'(res_data0), 64'(e0.data));
        check("res_idx", 64'(res_idx0), 64'(e0.idx));
        check("res_cycle", 64'(cyc), 64'(e0.cyc));
      end
    end
    if (done0) begin
      check("done_cycle", 64'(cyc), done_pend0 ? 64'(done_exp0) : 64'hFFFF_FFFF);
      done_pend0 = 1'b0;
    end
  end

  typedef struct {
    logic [15:0] pix, w0, w1, b0, b1, e0, e1;
    bit          ramp;
  } vec_t;
  vec_t vec[4];

  task automatic load_vec(input int v);
    int k;
    for (int i = 0; i < 4; i++) begin
      k = vec[v].ramp ? i + 1 : 1;
      pix_mem0[i]  = 16'(vec[v].pix * k);
      w_mem0[i]    = 16'(vec[v].w0 * k);
      w_mem0[4+i]  = 16'(vec[v].w1 * k);
    end
    b_mem0[0] = vec[v].b0;
    b_mem0[1] = vec[v].b1;
  endtask

  // Start a run at cycle t and queue the expected results:
  // neuron n reports at t+(n+1)*7+1, done at t+15.
  task automatic launch0(input int v, output int t);
    @(negedge clk);
    t = cyc;
    start0   = 1'b1;
    inp_cnt0 = 0;
    overlap0 = 1'b0;
    q0.push_back('{idx: 0, data: post(vec[v].e0), cyc: t + 8});
    q0.push_back('{idx: 1, data: post(vec[v].e1), cyc: t + 15});
    done_exp0  = t + 15;
    done_pend0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic run_small(input int v, input bit poke);
    int t;
    int guard;
    launch0(v, t);
    if (poke) begin
      // start and a stray nrn_out_ready mid-STREAM, start again on done
      while (cyc < t + 4) @(negedge clk);
      start0 = 1'b1;
      spur0  = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      spur0  = 1'b0;
      while (cyc < t + 15) @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
    end
    guard = 0;
    while (done_pend0 && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check("done_timeout", 64'(done_pend0), 64'd0);
    while (cyc < t + 16) @(negedge clk);
    #1;
    check("busy_after_done", 64'(busy0), 64'd0);
    check("inp_ready_count", 64'(inp_cnt0), 64'd8);
    check("clr_inp_overlap", 64'(overlap0), 64'd0);
    check("addr_hold", {pix_addr0, w_addr0, b_addr0}, {2'd3, 3'd7, 1'b1});
    repeat (3) @(negedge clk);
    #1;
    check("busy_stays_idle", 64'(busy0), 64'd0);
    check("queue_drained", 64'(q0.size()), 64'd0);
    q0.delete();
    done_pend0 = 1'b0;
  endtask

  // ---------------- default instance: 784 inputs x 10 neurons ----------------
  logic        start1 = 1'b0;
  logic        busy1, done1, nrn_clr1, inp_ready1, res_valid1;
  logic [9:0]  pix_addr1;
  logic [12:0] w_addr1;
  logic [3:0]  b_addr1, res_idx1;
  logic [15:0] pix_data1, w_data1, b_data1, inp_data1, weight1, bias1, res_data1;
  logic        nrdy1 = 1'b0;
  logic [15:0] nout1 = 16'h0;

  layer_sequencer dut1 (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
    .pix_addr(pix_addr1), .pix_data(pix_data1), .w_addr(w_addr1), .w_data(w_data1),
    .b_addr(b_addr1), .b_data(b_data1), .nrn_clr(nrn_clr1), .inp_ready(inp_ready1),
    .inp_data(inp_data1), .weight(weight1), .bias(bias1), .nrn_out(nout1),
    .nrn_out_ready(nrdy1), .res_valid(res_valid1), .res_idx(res_idx1),
    .res_data(res_data1)
  );

  logic [15:0] pix_mem1 [784];
  always @(posedge clk) begin
    pix_data1 <= pix_mem1[pix_addr1];
    w_data1   <= 16'(w_addr1) + 16'h0101;
    b_data1   <= {4'h0, b_addr1, 8'h00};
  end

  logic signed [31:0] acc1 = '0;
  int                 ncnt1 = 0;
  wire signed [31:0]  prod1 = ($signed(inp_data1) * $signed(weight1)) >>> 8;
  always @(posedge clk) begin
    nrdy1 <= 1'b0;
    if (reset || nrn_clr1) begin
      acc1  <= '0;
      ncnt1 <= 0;
    end else if (inp_ready1) begin
      acc1  <= acc1 + prod1;
      ncnt1 <= ncnt1 + 1;
      if (ncnt1 == 783) begin
        nrdy1 <= 1'b1;
        nout1 <= 16'(acc1 + prod1 + 32'($signed(bias1)));
      end
    end
  end

  exp_t q1[$];
  exp_t e1;
  bit   done_pend1 = 1'b0;
  int   done_exp1  = 0;
  int   inp_cnt1   = 0;
  int   max_w1     = 0;

  always @(negedge clk) begin
    if (inp_ready1) inp_cnt1++;
    if (int'(w_addr1) > max_w1) max_w1 = int'(w_addr1);
    if (res_valid1) begin
      if (q1.size() == 0) begin
        check("big_res_unexpected", 64'(res_valid1), 64'd0);
      end else begin
        e1 = q1.pop_front();
        check("big_res_data", 64'(res_data1), 64'(e1.data));
        check("big_res_idx", 64'(res_idx1), 64'(e1.idx));
        check("big_res_cycle", 64'(cyc), 64'(e1.cyc));
      end
    end
    if (done1) begin
      check("big_done_cycle", 64'(cyc), done_pend1 ? 64'(done_exp1) : 64'hFFFF_FFFF);
      done_pend1 = 1'b0;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int t;
    int guard;

    vec[0] = '{pix: 16'h0100, w0: 16'h0080, w1: 16'h0100, b0: 16'h0000, b1: 16'hFF00,
               e0: 16'h0200, e1: 16'h0300, ramp: 1'b0};
    vec[1] = '{pix: 16'h0100, w0: 16'hFF00, w1: 16'h0040, b0: 16'h0000, b1: 16'h0010,
               e0: 16'hFC00, e1: 16'h0110, ramp: 1'b0};
    vec[2] = '{pix: 16'h0200, w0: 16'h0180, w1: 16'hFFC0, b0: 16'h0100, b1: 16'h0000,
               e0: 16'h0D00, e1: 16'hFE00, ramp: 1'b0};
    vec[3] = '{pix: 16'h0100, w0: 16'h0100, w1: 16'h0080, b0: 16'h0000, b1: 16'h0000,
               e0: 16'h1E00, e1: 16'h0F00, ramp: 1'b1};
    for (int i = 0; i < 784; i++) pix_mem1[i] = 16'h0000;
    load_vec(0);

    // Reset values while reset is held
    repeat (3) @(negedge clk);
    #1;
    check("rst_ctrl", {busy0, done0, nrn_clr0, inp_ready0, res_valid0}, 64'd0);
    check("rst_result", {res_idx0, res_data0}, 64'd0);
    check("rst_addr", {pix_addr0, w_addr0, b_addr0}, 64'd0);
    check("rst_operands", {inp_data0, weight0, bias0}, 64'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("idle_no_start", 64'(busy0), 64'd0);

    // Table of vectors
    for (int v = 0; v < 4; v++) begin
      load_vec(v);
      run_small(v, 1'b0);
    end

    // start while busy and on the done cycle, stray nrn_out_ready
    load_vec(0);
    run_small(0, 1'b1);

    // Asynchronous reset during neuron 1 STREAM, then a clean rerun
    launch0(0, t);
    while (cyc < t + 10) @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_ctrl", {busy0, done0, nrn_clr0, inp_ready0, res_valid0}, 64'd0);
    check("midrst_result", {res_idx0, res_data0}, 64'd0);
    check("midrst_addr", {pix_addr0, w_addr0, b_addr0}, 64'd0);
    check("midrst_operands", {inp_data0, weight0, bias0}, 64'd0);
    q0.delete();
    done_pend0 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("midrst_idle", 64'(busy0), 64'd0);
    run_small(0, 1'b0);

    // Full default layer: zero pixels, result equals bias 0x0100*k
    @(negedge clk);
    t = cyc;
    start1   = 1'b1;
    inp_cnt1 = 0;
    max_w1   = 0;
    for (int k = 0; k < 10; k++)
      q1.push_back('{idx: k, data: 16'(16'h0100 * k), cyc: t + (k + 1) * 787 + 1});
    done_exp1  = t + 7871;
    done_pend1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    guard = 0;
    while (done_pend1 && guard < 9000) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check("big_done_timeout", 64'(done_pend1), 64'd0);
    @(negedge clk);
    #1;
    check("big_busy_after_done", 64'(busy1), 64'd0);
    check("big_inp_ready_count", 64'(inp_cnt1), 64'd7840);
    check("big_max_w_addr", 64'(max_w1), 64'd7839);
    check("big_queue_drained", 64'(q1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
